// File: rtl/modexp_datapath.sv
// Right-to-left square-and-multiply datapath for m^e mod n, driven by an external FSM controller.
// Optional cycle counter output enabled by defining MODEXP_CYCLE_COUNT_EN.
module modexp_datapath #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data_in,
   input  logic             update_e,
   input  logic             update_n,
   input  logic             initialize,
   input  logic             en_multiply,
   input  logic             en_modulo,
   input  logic             done,
   output logic             is_init_done,
   output logic             is_multiplication_done,
   output logic [WIDTH-1:0] result,
   output logic             result_valid
`ifdef MODEXP_CYCLE_COUNT_EN
   ,
   output logic [15:0]      cycle_count
`endif
);

   localparam int PW = 2 * WIDTH;

   logic [WIDTH-1:0] e_q, e_d;
   logic [WIDTH-1:0] n_q, n_d;
   logic [WIDTH-1:0] base_q, base_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] exp_sh_q, exp_sh_d;
   logic [PW-1:0]    prod_a_q, prod_a_d;
   logic [PW-1:0]    prod_b_q, prod_b_d;
   logic             busy_q, busy_d;
   logic             init_done_q, init_done_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             result_valid_q, result_valid_d;

   logic [PW-1:0]    acc_w, base_w, data_w;
   logic             init_start;

   // Reduction guarded against n == 0 so simulation never divides by zero.
   function automatic logic [WIDTH-1:0] mod_n(input logic [PW-1:0] x, input logic [WIDTH-1:0] n);
      logic [PW-1:0] r;
      if (n == '0) begin
         r = '0;
      end else begin
         r = x % {{WIDTH{1'b0}}, n};
      end
      return r[WIDTH-1:0];
   endfunction

   assign acc_w      = {{WIDTH{1'b0}}, acc_q};
   assign base_w     = {{WIDTH{1'b0}}, base_q};
   assign data_w     = {{WIDTH{1'b0}}, data_in};
   assign init_start = initialize & ~init_done_q;

   always_comb begin
      e_d            = e_q;
      n_d            = n_q;
      base_d         = base_q;
      acc_d          = acc_q;
      exp_sh_d       = exp_sh_q;
      prod_a_d       = prod_a_q;
      prod_b_d       = prod_b_q;
      busy_d         = busy_q;
      result_d       = result_q;
      result_valid_d = 1'b0;
      init_done_d    = initialize;

      if (update_e && !busy_q) e_d = data_in;
      if (update_n && !busy_q) n_d = data_in;

      // A fresh initialize restarts the run even if one is in flight.
      if (init_start) begin
         busy_d = 1'b1;
         if (n_q == '0) begin
            base_d   = '0;
            acc_d    = '0;
            exp_sh_d = '0;
         end else begin
            base_d   = mod_n(data_w, n_q);
            acc_d    = (n_q == WIDTH'(1)) ? '0 : WIDTH'(1);
            exp_sh_d = e_q;
         end
      end else if (busy_q) begin
         if (done) begin
            result_d       = acc_q;
            result_valid_d = 1'b1;
            busy_d         = 1'b0;
         end else if (en_modulo) begin
            acc_d    = mod_n(prod_a_q, n_q);
            base_d   = mod_n(prod_b_q, n_q);
            exp_sh_d = exp_sh_q >> 1;
         end else if (en_multiply) begin
            prod_a_d = exp_sh_q[0] ? (acc_w * base_w) : acc_w;
            prod_b_d = base_w * base_w;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         e_q            <= '0;
         n_q            <= '0;
         base_q         <= '0;
         acc_q          <= '0;
         exp_sh_q       <= '0;
         prod_a_q       <= '0;
         prod_b_q       <= '0;
         busy_q         <= 1'b0;
         init_done_q    <= 1'b0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
      end else begin
         e_q            <= e_d;
         n_q            <= n_d;
         base_q         <= base_d;
         acc_q          <= acc_d;
         exp_sh_q       <= exp_sh_d;
         prod_a_q       <= prod_a_d;
         prod_b_q       <= prod_b_d;
         busy_q         <= busy_d;
         init_done_q    <= init_done_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
      end
   end

   assign is_init_done           = init_done_q;
   assign is_multiplication_done = busy_q & (exp_sh_q == '0);
   assign result                 = result_q;
   assign result_valid           = result_valid_q;

`ifdef MODEXP_CYCLE_COUNT_EN
   logic [15:0] cnt_q, cnt_d;

   // Counts busy cycles, saturating; frozen once the run completes.
   always_comb begin
      cnt_d = cnt_q;
      if (init_start) begin
         cnt_d = '0;
      end else if (busy_q && cnt_q != 16'hFFFF) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cycle_count = cnt_q;
`endif

endmodule

// File: tb/tb_modexp_datapath.sv
// Scoreboard bench for modexp_datapath: a controller-style driver pushes expected results,
// an independent monitor pops and compares on every result_valid.
module tb_modexp_datapath;

   localparam int WIDTH = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [WIDTH-1:0] data_in;
   logic             update_e, update_n, initialize, en_multiply, en_modulo, done;
   logic             is_init_done, is_multiplication_done, result_valid;
   logic [WIDTH-1:0] result;
`ifdef MODEXP_CYCLE_COUNT_EN
   logic [15:0]      cycle_count;
`endif

   int               n_vec  = 0;
   int               n_fail = 0;
   logic [WIDTH-1:0] exp_q[$];

   always #5 clk = ~clk;

   modexp_datapath #(.WIDTH(WIDTH)) dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .data_in                (data_in),
      .update_e               (update_e),
      .update_n               (update_n),
      .initialize             (initialize),
      .en_multiply            (en_multiply),
      .en_modulo              (en_modulo),
      .done                   (done),
      .is_init_done           (is_init_done),
      .is_multiplication_done (is_multiplication_done),
      .result                 (result),
      .result_valid           (result_valid)
`ifdef MODEXP_CYCLE_COUNT_EN
      ,
      .cycle_count            (cycle_count)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Monitor: every result_valid must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && result_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_result_valid: got result %0d, expected no output", result);
         end else begin
            check("result", {16'b0, result}, {16'b0, exp_q.pop_front()});
         end
      end
   end

   task automatic key_load(input logic [WIDTH-1:0] e, input logic [WIDTH-1:0] n);
      @(negedge clk);
      data_in  = e;
      update_e = 1'b1;
      @(negedge clk);
      update_e = 1'b0;
      data_in  = n;
      update_n = 1'b1;
      @(negedge clk);
      update_n = 1'b0;
   endtask

   // Back-to-back controller; abort_at>0 pulses reset after that many iterations.
   task automatic run(input string tag, input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] exp_res,
                      input int exp_iters, input int abort_at, input bit poke_e);
      int iters = 0;
      int guard = 0;
      @(negedge clk);
      data_in    = m;
      initialize = 1'b1;
      @(negedge clk);
      while (!is_init_done && guard < 4) begin
         @(negedge clk);
         guard++;
      end
      check({tag, "_init_done"}, {31'b0, is_init_done}, 32'd1);
      initialize = 1'b0;
      if (poke_e) begin
         data_in  = 16'd5;
         update_e = 1'b1;
         @(negedge clk);
         update_e = 1'b0;
      end
      while (!is_multiplication_done && iters < 40) begin
         en_multiply = 1'b1;
         @(negedge clk);
         en_multiply = 1'b0;
         en_modulo   = 1'b1;
         @(negedge clk);
         en_modulo   = 1'b0;
         iters++;
         if (iters == abort_at) begin
            rst_n = 1'b0;
            @(negedge clk);
            check({tag, "_rst_result"}, {16'b0, result}, 32'd0);
            check({tag, "_rst_valid"}, {31'b0, result_valid}, 32'd0);
            check({tag, "_rst_init_done"}, {31'b0, is_init_done}, 32'd0);
            check({tag, "_rst_mult_done"}, {31'b0, is_multiplication_done}, 32'd0);
            rst_n = 1'b1;
            return;
         end
      end
      check({tag, "_iterations"}, iters, exp_iters);
      exp_q.push_back(exp_res);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      check({tag, "_valid_pulse"}, {31'b0, result_valid}, 32'd1);
      @(negedge clk);
      check({tag, "_valid_one_cycle"}, {31'b0, result_valid}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n       = 1'b0;
      data_in     = '0;
      update_e    = 1'b0;
      update_n    = 1'b0;
      initialize  = 1'b0;
      en_multiply = 1'b0;
      en_modulo   = 1'b0;
      done        = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_result", {16'b0, result}, 32'd0);
      check("reset_valid", {31'b0, result_valid}, 32'd0);
      check("reset_init_done", {31'b0, is_init_done}, 32'd0);
      check("reset_mult_done", {31'b0, is_multiplication_done}, 32'd0);
      rst_n = 1'b1;

      // 4^3 mod 33 = 31; update_e during the run must be ignored
      key_load(16'd3, 16'd33);
      run("c1", 16'd4, 16'd31, 2, 0, 1'b1);

      // done while idle: no pulse, result held
      @(negedge clk);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      check("idle_done_valid", {31'b0, result_valid}, 32'd0);
      check("idle_done_result", {16'b0, result}, 32'd31);

      // e was not changed by the ignored load: 4^5 mod 33 = 1
      key_load(16'd5, 16'd33);
      run("c6", 16'd4, 16'd1, 3, 0, 1'b0);

      // 2^7 mod 33 = 29, three iterations
      key_load(16'd7, 16'd33);
      run("c2", 16'd2, 16'd29, 3, 0, 1'b0);

      // e=0
      key_load(16'd0, 16'd33);
      run("c3a", 16'd5, 16'd1, 0, 0, 1'b0);
      key_load(16'd0, 16'd1);
      run("c3b", 16'd5, 16'd0, 0, 0, 1'b0);

      // (-1)^odd mod 97
      key_load(16'hFFFF, 16'd97);
      run("c4", 16'd96, 16'd96, 16, 0, 1'b0);

      // reset mid-run, then rerun with cleared keys
      key_load(16'd7, 16'd33);
      run("c5_abort", 16'd2, 16'd29, 3, 2, 1'b0);
      run("c5_rerun", 16'd2, 16'd0, 0, 0, 1'b0);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
